// File: rtl/conv_encoder_param.sv
// Parametrised rate-1/N feed-forward convolutional encoder with valid/ready
// flow control and per-frame zero-tail flush or truncation.
module conv_encoder_param #(
  parameter int K = 3,
  parameter int N = 2,
  parameter logic [N*K-1:0] G = {3'b111, 3'b101}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_bit,
  input  logic         in_last,
  input  logic         tail_en,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sym,
  output logic         out_last,
  output logic         busy
);

  typedef enum logic {
    ST_DATA = 1'b0,
    ST_TAIL = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [K-2:0]   s_q, s_d;
  logic [3:0]     tcnt_q, tcnt_d;
  logic           out_valid_q, out_valid_d;
  logic [N-1:0]   out_sym_q, out_sym_d;
  logic           out_last_q, out_last_d;
  logic           frame_open_q, frame_open_d;

  logic           load_ok;
  logic           din;
  logic [K-1:0]   w;
  logic [N-1:0]   sym;

  assign load_ok = !out_valid_q || out_ready;
  assign din     = (state_q == ST_DATA) ? in_bit : 1'b0;
  assign w       = {din, s_q};

  always_comb begin
    sym = '0;
    for (int i = 0; i < N; i++) begin
      sym[i] = ^(w & G[i*K +: K]);
    end
  end

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    tcnt_d       = tcnt_q;
    out_valid_d  = out_valid_q;
    out_sym_d    = out_sym_q;
    out_last_d   = out_last_q;
    frame_open_d = frame_open_q;
    in_ready     = 1'b0;

    if (out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_DATA: begin
        in_ready = load_ok && !reset;
        if (in_valid && load_ok) begin
          out_valid_d  = 1'b1;
          out_sym_d    = sym;
          out_last_d   = 1'b0;
          s_d          = w[K-1:1];
          frame_open_d = 1'b1;
          if (in_last) begin
            frame_open_d = 1'b0;
            if (tail_en) begin
              state_d = ST_TAIL;
              tcnt_d  = 4'(K-1);
            end else begin
              // Truncated frame: next frame restarts from the zero state.
              out_last_d = 1'b1;
              s_d        = '0;
            end
          end
        end
      end
      ST_TAIL: begin
        if (load_ok) begin
          out_valid_d = 1'b1;
          out_sym_d   = sym;
          out_last_d  = 1'b0;
          s_d         = w[K-1:1];
          tcnt_d      = tcnt_q - 4'd1;
          if (tcnt_q == 4'd1) begin
            out_last_d = 1'b1;
            state_d    = ST_DATA;
          end
        end
      end
      default: state_d = ST_DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_DATA;
      s_q          <= '0;
      tcnt_q       <= '0;
      out_valid_q  <= 1'b0;
      out_sym_q    <= '0;
      out_last_q   <= 1'b0;
      frame_open_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      tcnt_q       <= tcnt_d;
      out_valid_q  <= out_valid_d;
      out_sym_q    <= out_sym_d;
      out_last_q   <= out_last_d;
      frame_open_q <= frame_open_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sym   = out_sym_q;
  assign out_last  = out_last_q;
  assign busy      = frame_open_q || (state_q == ST_TAIL);

endmodule

// File: tb/tb_conv_encoder_param.sv
// Randomised self-checking bench for conv_encoder_param; expected symbols come
// from a convolution model over the input history of each frame.
module tb_conv_encoder_param;

  localparam int KA = 3;
  localparam int NA = 2;
  localparam logic [5:0] GA = {3'b111, 3'b101};
  localparam int KB = 5;
  localparam int NB = 3;
  localparam logic [14:0] GB = {5'b10011, 5'b11101, 5'b10111};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic a_in_valid, a_in_ready, a_in_bit, a_in_last, a_tail_en;
  logic a_out_valid, a_out_ready, a_out_last, a_busy;
  logic [NA-1:0] a_out_sym;
  logic b_in_valid, b_in_ready, b_in_bit, b_in_last, b_tail_en;
  logic b_out_valid, b_out_ready, b_out_last, b_busy;
  logic [NB-1:0] b_out_sym;

  conv_encoder_param #(.K(KA), .N(NA), .G(GA)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_bit(a_in_bit), .in_last(a_in_last), .tail_en(a_tail_en),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sym(a_out_sym),
    .out_last(a_out_last), .busy(a_busy)
  );

  conv_encoder_param #(.K(KB), .N(NB), .G(GB)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_bit(b_in_bit), .in_last(b_in_last), .tail_en(b_tail_en),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sym(b_out_sym),
    .out_last(b_out_last), .busy(b_busy)
  );

  typedef struct packed {
    logic b;
    logic last;
    logic tail;
  } beat_t;

  beat_t      beats_q[$];
  logic [4:0] exp_q[$];
  logic [4:0] got_q[$];
  logic       log_in_ready[$];
  logic       log_busy[$];
  logic       log_acc[$];
  logic       log_ov[$];
  logic       log_ol[$];
  int         stall_err;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic add_frame(input logic [15:0] bits, input int len, input logic tail);
    beat_t bt;
    for (int j = 0; j < len; j++) begin
      bt.b    = bits[j];
      bt.last = (j == len - 1);
      bt.tail = tail;
      beats_q.push_back(bt);
    end
  endtask

  // Output bit i is the mod-2 sum of the bit delayed by j steps times tap K-1-j.
  function automatic logic [3:0] calc_sym(input logic [8:0] h, input int k, input int n,
                                          input logic [35:0] g);
    logic [3:0] r;
    logic p;
    r = '0;
    for (int i = 0; i < n; i++) begin
      p = 1'b0;
      for (int j = 0; j < k; j++) p = p ^ (h[j] & g[i*k + k - 1 - j]);
      r[i] = p;
    end
    return r;
  endfunction

  task automatic build_model(input int k, input int n, input logic [35:0] g);
    logic [8:0] hist;
    exp_q.delete();
    hist = '0;
    for (int x = 0; x < beats_q.size(); x++) begin
      hist = {hist[7:0], beats_q[x].b};
      exp_q.push_back({beats_q[x].last && !beats_q[x].tail, calc_sym(hist, k, n, g)});
      if (beats_q[x].last) begin
        if (beats_q[x].tail) begin
          for (int t = 1; t < k; t++) begin
            hist = {hist[7:0], 1'b0};
            exp_q.push_back({t == k - 1, calc_sym(hist, k, n, g)});
          end
        end
        hist = '0;
      end
    end
  endtask

  // Drives beats_q into one instance and collects every symbol handed downstream.
  task automatic run_stream(input logic sel, input int rdy_mode, input logic gaps);
    int idx = 0;
    int cyc = 0;
    logic rdy, vld, ov, ir, ol, bz, stalled;
    logic [3:0] os;
    logic [4:0] held;
    beat_t bt;
    got_q.delete(); log_in_ready.delete(); log_busy.delete();
    log_acc.delete(); log_ov.delete(); log_ol.delete();
    stall_err = 0;
    stalled = 1'b0;
    held = '0;
    @(negedge clk);
    while ((idx < beats_q.size() || got_q.size() < exp_q.size()) && cyc < 3000) begin
      case (rdy_mode)
        1:       rdy = ($urandom_range(0, 1) == 1);
        2:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'b1;
      endcase
      vld = (idx < beats_q.size()) && (!gaps || $urandom_range(0, 3) != 0);
      bt = (idx < beats_q.size()) ? beats_q[idx] : '0;
      if (sel) begin
        b_out_ready = rdy; b_in_valid = vld; b_in_bit = bt.b;
        b_in_last = bt.last; b_tail_en = bt.tail;
      end else begin
        a_out_ready = rdy; a_in_valid = vld; a_in_bit = bt.b;
        a_in_last = bt.last; a_tail_en = bt.tail;
      end
      #1;
      ov = sel ? b_out_valid : a_out_valid;
      ir = sel ? b_in_ready : a_in_ready;
      ol = sel ? b_out_last : a_out_last;
      bz = sel ? b_busy : a_busy;
      os = sel ? {1'b0, b_out_sym} : {2'b00, a_out_sym};
      if (stalled && (!ov || {ol, os} !== held)) stall_err++;
      if (ov && rdy) got_q.push_back({ol, os});
      stalled = ov && !rdy;
      held = {ol, os};
      log_in_ready.push_back(ir); log_busy.push_back(bz);
      log_acc.push_back(vld && ir); log_ov.push_back(ov); log_ol.push_back(ol);
      if (vld && ir) idx++;
      cyc++;
      @(negedge clk);
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_out_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_in_valid = 1'b0; a_in_bit = 1'b0; a_in_last = 1'b0; a_tail_en = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_bit = 1'b0; b_in_last = 1'b0; b_tail_en = 1'b0; b_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (a_in_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_in_ready: got %b expected 0", a_in_ready); end
    n_cmp++;
    if ({a_out_valid, a_out_last, a_busy} !== 3'b000) begin
      n_bad++; $display("[TB] FAIL reset_flags: got %b expected 000", {a_out_valid, a_out_last, a_busy});
    end
    n_cmp++;
    if (a_out_sym !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_sym: got %b expected 00", a_out_sym); end
    n_cmp++;
    if ({b_out_valid, b_busy} !== 2'b00) begin
      n_bad++; $display("[TB] FAIL reset_b_flags: got %b expected 00", {b_out_valid, b_busy});
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (a_in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL post_reset_ready: got %b expected 1", a_in_ready); end
  endtask

  task automatic test_tail();
    int f = -1;
    int c = -1;
    beats_q.delete();
    add_frame(16'b1101, 4, 1'b1);
    build_model(KA, NA, 36'(GA));
    run_stream(1'b0, 0, 1'b0);
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_bad++; $display("[TB] FAIL tail_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int x = 0; x < exp_q.size() && x < got_q.size(); x++) begin
      n_cmp++;
      if (got_q[x] !== exp_q[x]) begin
        n_bad++; $display("[TB] FAIL tail_sym[%0d]: got %b expected %b", x, got_q[x], exp_q[x]);
      end
    end
    for (int x = 0; x < log_ov.size(); x++) begin
      if (log_ov[x] && f < 0) f = x;
      if (log_ov[x] && log_ol[x] && c < 0) c = x;
    end
    n_cmp++;
    if (c - f !== 5) begin n_bad++; $display("[TB] FAIL tail_consecutive: got span %0d expected 5", c - f); end
    if (c > 0) begin
      n_cmp++;
      if ({log_busy[c-1], log_busy[c], log_in_ready[c]} !== 3'b101) begin
        n_bad++; $display("[TB] FAIL tail_busy_fall: got %b expected 101",
                          {log_busy[c-1], log_busy[c], log_in_ready[c]});
      end
    end
  endtask

  task automatic test_truncate();
    int f = -1;
    int run = 0;
    beats_q.delete();
    add_frame(16'b1101, 4, 1'b0);
    add_frame(16'b11, 2, 1'b0);
    build_model(KA, NA, 36'(GA));
    run_stream(1'b0, 0, 1'b0);
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_bad++; $display("[TB] FAIL trunc_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int x = 0; x < exp_q.size() && x < got_q.size(); x++) begin
      n_cmp++;
      if (got_q[x] !== exp_q[x]) begin
        n_bad++; $display("[TB] FAIL trunc_sym[%0d]: got %b expected %b", x, got_q[x], exp_q[x]);
      end
    end
    for (int x = 0; x < log_acc.size(); x++) begin
      if (log_acc[x] && f < 0) f = x;
      if (f >= 0 && x == f + run && log_acc[x]) run++;
    end
    n_cmp++;
    if (run !== 6) begin n_bad++; $display("[TB] FAIL trunc_no_gap: got %0d back-to-back accepts expected 6", run); end
  endtask

  task automatic test_single_bit();
    int a = -1;
    beats_q.delete();
    add_frame(16'b1, 1, 1'b1);
    build_model(KA, NA, 36'(GA));
    run_stream(1'b0, 0, 1'b0);
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_bad++; $display("[TB] FAIL single_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int x = 0; x < exp_q.size() && x < got_q.size(); x++) begin
      n_cmp++;
      if (got_q[x] !== exp_q[x]) begin
        n_bad++; $display("[TB] FAIL single_sym[%0d]: got %b expected %b", x, got_q[x], exp_q[x]);
      end
    end
    for (int x = 0; x < log_acc.size(); x++) if (log_acc[x] && a < 0) a = x;
    n_cmp++;
    if (a < 0 || a + 3 >= log_in_ready.size()) begin
      n_bad++; $display("[TB] FAIL single_ready_gap: got log length %0d expected accept plus 3 cycles", log_in_ready.size());
    end else if ({log_in_ready[a+1], log_in_ready[a+2], log_in_ready[a+3]} !== 3'b001) begin
      n_bad++; $display("[TB] FAIL single_ready_gap: got %b expected 001",
                        {log_in_ready[a+1], log_in_ready[a+2], log_in_ready[a+3]});
    end
  endtask

  task automatic test_backpressure();
    beats_q.delete();
    add_frame(16'b1101, 4, 1'b1);
    build_model(KA, NA, 36'(GA));
    run_stream(1'b0, 2, 1'b0);
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_bad++; $display("[TB] FAIL bp_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int x = 0; x < exp_q.size() && x < got_q.size(); x++) begin
      n_cmp++;
      if (got_q[x] !== exp_q[x]) begin
        n_bad++; $display("[TB] FAIL bp_sym[%0d]: got %b expected %b", x, got_q[x], exp_q[x]);
      end
    end
    n_cmp++;
    if (stall_err !== 0) begin n_bad++; $display("[TB] FAIL bp_hold: got %0d unstable stalls expected 0", stall_err); end
  endtask

  task automatic test_reset_mid_tail();
    logic [3:0] bits;
    bits = 4'b1101;
    a_out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      a_in_valid = 1'b1; a_in_bit = bits[j]; a_in_last = (j == 3); a_tail_en = 1'b1;
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (a_in_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL midtail_ready_in_reset: got %b expected 0", a_in_ready); end
    @(negedge clk);
    n_cmp++;
    if ({a_out_valid, a_out_last, a_busy} !== 3'b000) begin
      n_bad++; $display("[TB] FAIL midtail_cleared: got %b expected 000", {a_out_valid, a_out_last, a_busy});
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (a_in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL midtail_ready_after: got %b expected 1", a_in_ready); end
    beats_q.delete();
    add_frame(16'b1, 1, 1'b1);
    build_model(KA, NA, 36'(GA));
    run_stream(1'b0, 0, 1'b0);
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_bad++; $display("[TB] FAIL midtail_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    for (int x = 0; x < exp_q.size() && x < got_q.size(); x++) begin
      n_cmp++;
      if (got_q[x] !== exp_q[x]) begin
        n_bad++; $display("[TB] FAIL midtail_sym[%0d]: got %b expected %b", x, got_q[x], exp_q[x]);
      end
    end
  endtask

  task automatic test_k5_impulse();
    beats_q.delete();
    add_frame(16'b1, 1, 1'b1);
    build_model(KB, NB, 36'(GB));
    run_stream(1'b1, 0, 1'b0);
    n_cmp++;
    if (got_q.size() !== 5) begin n_bad++; $display("[TB] FAIL k5_count: got %0d expected 5", got_q.size()); end
    for (int x = 0; x < exp_q.size() && x < got_q.size(); x++) begin
      n_cmp++;
      if (got_q[x] !== exp_q[x]) begin
        n_bad++; $display("[TB] FAIL k5_sym[%0d]: got %b expected %b", x, got_q[x], exp_q[x]);
      end
    end
  endtask

  task automatic test_random(input logic sel);
    beats_q.delete();
    for (int f = 0; f < 6; f++) begin
      add_frame(16'($urandom), $urandom_range(1, 12), ($urandom_range(0, 1) == 1));
    end
    if (sel) build_model(KB, NB, 36'(GB));
    else     build_model(KA, NA, 36'(GA));
    run_stream(sel, 1, 1'b1);
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_bad++; $display("[TB] FAIL rand%0d_count: got %0d expected %0d", sel, got_q.size(), exp_q.size());
    end
    for (int x = 0; x < exp_q.size() && x < got_q.size(); x++) begin
      n_cmp++;
      if (got_q[x] !== exp_q[x]) begin
        n_bad++; $display("[TB] FAIL rand%0d_sym[%0d]: got %b expected %b", sel, x, got_q[x], exp_q[x]);
      end
    end
    n_cmp++;
    if (stall_err !== 0) begin
      n_bad++; $display("[TB] FAIL rand%0d_hold: got %0d unstable stalls expected 0", sel, stall_err);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_tail();
    test_truncate();
    test_single_bit();
    test_backpressure();
    test_reset_mid_tail();
    test_k5_impulse();
    test_random(1'b0);
    test_random(1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
